// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- one register slice of a stallable, flushable pipeline.
//
// Each payload moves through the stage with exactly one cycle of latency.
// A per-stage bit of the shared stall vector either inserts a bubble (the
// next stage is free) or freezes the stage (the next stage is also
// stalled). flush discards everything the stage holds.
//
// Build option:
//   PIPE_STAGE_SKID_EN  when defined, adds a one-entry skid buffer. in_ready
//                       then depends only on registered state, so there is
//                       no combinational path from out_ready to in_ready.
//                       Without it, in_ready follows out_ready
//                       combinationally.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        synchronous active-low reset
//   stall      stall vector; bit STAGE_IDX stalls this stage, bit
//              STAGE_IDX+1 reports whether the next stage is stalled
//   flush      discard held and incoming payloads
//   in_valid   upstream payload valid
//   in_ready   this stage accepts a payload this cycle
//   in_data    upstream payload
//   in_side    upstream sideband (held across bubbles)
//   out_valid  registered payload valid
//   out_ready  downstream accepts the payload
//   out_data   registered payload (BUBBLE_VAL on bubble/flush/reset)
//   out_side   registered sideband
module pipe_stage_reg #(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       SIDE_W     = 1,
  parameter int unsigned       STAGE_IDX  = 2,
  parameter int unsigned       STALL_W    = 6,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SIDE_W-1:0]  in_side,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [SIDE_W-1:0]  out_side
);

  logic              s_stall;
  logic              n_stall;
  logic              slot_free;
  logic              in_fire;
  logic              out_fire;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [SIDE_W-1:0] out_side_q,  out_side_d;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [SIDE_W-1:0] skid_side_q,  skid_side_d;
`endif

  // Only two bits of the shared stall vector matter to this stage.
  logic unused_stall;
  assign unused_stall = ^stall;

  assign s_stall   = stall[STAGE_IDX];
  assign n_stall   = stall[STAGE_IDX+1];
  assign slot_free = !out_valid_q || out_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign in_fire   = in_valid && in_ready;

`ifdef PIPE_STAGE_SKID_EN
  // Depends only on registers and the stall/flush/reset controls.
  assign in_ready = rst && !s_stall && !flush && !skid_valid_q;
`else
  assign in_ready = rst && !s_stall && !flush && slot_free;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_side  = out_side_q;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_side_d  = out_side_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_side_d  = skid_side_q;
`endif

    if (flush) begin
      out_valid_d = 1'b0;
      out_data_d  = BUBBLE_VAL;
      out_side_d  = '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_valid_d = 1'b0;
`endif
    end else if (s_stall && n_stall) begin
      // Frozen: only a completed handshake may retire the output.
      if (out_fire) begin
        out_valid_d = 1'b0;
      end
    end else if (s_stall) begin
      // Next stage can move: a held skid entry still advances, otherwise
      // a bubble is inserted. The sideband is deliberately kept.
      if (slot_free) begin
`ifdef PIPE_STAGE_SKID_EN
        if (skid_valid_q) begin
          out_valid_d  = 1'b1;
          out_data_d   = skid_data_q;
          out_side_d   = skid_side_q;
          skid_valid_d = 1'b0;
        end else begin
          out_valid_d = 1'b0;
          out_data_d  = BUBBLE_VAL;
        end
`else
        out_valid_d = 1'b0;
        out_data_d  = BUBBLE_VAL;
`endif
      end
    end else begin
      if (slot_free) begin
`ifdef PIPE_STAGE_SKID_EN
        // A full skid blocks in_ready, so it never competes with in_fire.
        if (skid_valid_q) begin
          out_valid_d  = 1'b1;
          out_data_d   = skid_data_q;
          out_side_d   = skid_side_q;
          skid_valid_d = 1'b0;
        end else if (in_fire) begin
          out_valid_d = 1'b1;
          out_data_d  = in_data;
          out_side_d  = in_side;
        end else begin
          out_valid_d = 1'b0;
        end
`else
        if (in_fire) begin
          out_valid_d = 1'b1;
          out_data_d  = in_data;
          out_side_d  = in_side;
        end else begin
          out_valid_d = 1'b0;
        end
`endif
      end
`ifdef PIPE_STAGE_SKID_EN
      else if (in_fire) begin
        // Output is blocked; park the accepted payload.
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
        skid_side_d  = in_side;
      end
`endif
    end
  end

  // Stage boundary: output register (and optional skid entry).
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= BUBBLE_VAL;
      out_side_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_side_q  <= out_side_d;
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      skid_valid_q <= 1'b0;
    end else begin
      skid_valid_q <= skid_valid_d;
    end
  end

  // Skid payload is qualified by skid_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    skid_data_q <= skid_data_d;
    skid_side_q <= skid_side_d;
  end
`endif

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32: payload width in bits, legal range 1..256.
REQ-002 Parameter SIDE_W, default 1: sideband width, held across bubbles (delay-slot style flags).
REQ-003 Parameter STAGE_IDX, default 2: index of this stage's bit in stall; legal range 0..STALL_W-2.
REQ-004 Parameter STALL_W, default 6: stall vector width.
REQ-005 Parameter BUBBLE_VAL, default 0: payload value driven on bubble, flush and reset.
REQ-006 Port clk  in  1: single clock; all state updates on its rising edge.
REQ-007 Port rst  in  1: reset, synchronous, active-low; sampled on rising clk.
REQ-008 Port stall  in  STALL_W: pipeline stall vector from the stall controller.
REQ-009 Port flush  in  1: discard all held and incoming data when high.
REQ-010 Port in_valid  in  1: upstream payload valid.
REQ-011 Port in_ready  out  1: stage accepts payload this cycle.
REQ-012 Port in_data  in  DATA_W: upstream payload.
REQ-013 Port in_side  in  SIDE_W: upstream sideband.
REQ-014 Port out_valid  out  1: registered payload valid.
REQ-015 Port out_ready  in  1: downstream accepts payload.
REQ-016 Port out_data  out  DATA_W: registered payload.
REQ-017 Port out_side  out  SIDE_W: registered sideband.

Function
REQ-018 Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready; slot_free = !out_valid | out_ready; S = stall[STAGE_IDX]; N = stall[STAGE_IDX+1].
REQ-019 Update priority, highest first: reset, flush, stall-bubble, stall-hold, normal transfer.
REQ-020 Flush (rst high): next cycle out_valid=0, out_data=BUBBLE_VAL, out_side=0, skid empty; in_ready low during the flush cycle.
REQ-021 in_ready is 0 whenever S=1 or flush=1.
REQ-022 Stall-bubble (S=1, N=0, slot_free=1, no held data to advance): load out_valid=0, out_data=BUBBLE_VAL; out_side retains its value.
REQ-023 Stall-hold (S=1, N=1): out_valid, out_data, out_side and skid unchanged, except out_valid drops to 0 after out_fire.
REQ-024 Normal (S=0): on in_fire with slot_free, in_data/in_side load into output with out_valid=1 next cycle; latency exactly 1 cycle.
REQ-025 Output with out_valid=1 and out_ready=0 holds data, valid and sideband stable until out_fire.
REQ-026 After out_fire with no in_fire and no held data, out_valid=0 next cycle; out_data unchanged.
REQ-027 No payload is duplicated or dropped except by flush or reset.

Reset
REQ-028 rst low at a rising edge: out_valid=0, out_data=BUBBLE_VAL, out_side=0, skid empty, in_ready=0 while rst low.
REQ-029 Reset mid-transfer discards held payloads; in_ready may assert the first cycle after rst returns high.

Configuration
REQ-030 Macro PIPE_STAGE_SKID_EN compiles in a one-entry skid buffer.
REQ-031 Without PIPE_STAGE_SKID_EN: in_ready = !S & !flush & slot_free (combinational from out_ready).
REQ-032 With PIPE_STAGE_SKID_EN: in_ready = !S & !flush & skid empty, registered, no combinational path from out_ready.
REQ-033 With PIPE_STAGE_SKID_EN: in_fire while output held (out_valid=1, out_ready=0) stores payload in skid; on next slot_free skid moves to output before any new input or bubble.
REQ-034 With PIPE_STAGE_SKID_EN: stall-bubble applies only when skid empty; a full skid advances into a free output during stall.
REQ-035 Both builds deliver identical payload order and 1-cycle latency when out_ready is held high.

Verification
REQ-036 rst low 2 cycles, in_valid=1, in_data=0xDEADBEEF -> out_valid=0, out_data=0, out_side=0, in_ready=0; first rst-high cycle in_ready=1.
REQ-037 S=0, out_ready=1, stream in_data 1,2,3 back-to-back -> out_data 1,2,3 on cycles +1,+2,+3, out_valid=1 each.
REQ-038 out_valid=1, out_data=0x55, in_side=1 stored; stall=6'b000100 -> out_valid=0, out_data=BUBBLE_VAL, out_side=1; stall=6'b001100 -> all outputs unchanged.
REQ-039 out_ready=0 with out_data=0xA held, in_fire of 0xB (SKID_EN) -> in_ready=0, out_data=0xA; release out_ready -> 0xA then 0xB consecutively; without SKID_EN in_ready=0 throughout.
REQ-040 flush=1 concurrent with in_fire attempt, S=0, skid full -> next cycle out_valid=0, out_data=BUBBLE_VAL, skid empty, no later emission of either payload.
